pwm_duty_sched: RTL and testbench

PWM_DUTY_SCHED -- requirements
Module: pwm_duty_sched

---
 rtl/pwm_duty_sched.sv | 160 ++++++++++++++++
 tb/tb_pwm_duty_sched.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_sched.sv
// PWM duty scheduler: request handshake, duty clamping, per-period ramping and fault shutdown.
// Define PWM_DUTY_SCHED_SOFTSTART_EN for stepped ramping; otherwise duty jumps straight to target.
module pwm_duty_sched #(
    parameter int DUTY_MAX = 3500,
    parameter int DUTY_MIN = 150,
    parameter int STEP     = 10
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [11:0] req_duty,
    output logic        req_ready,
    input  logic        period_end,
    input  logic        fault,
    input  logic        fault_clr,
    output logic [11:0] duty_out,
    output logic        pwm_en,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;

`ifdef PWM_DUTY_SCHED_SOFTSTART_EN
    localparam bit SOFTSTART = 1'b1;
`else
    localparam bit SOFTSTART = 1'b0;
`endif

    // Without soft-start the step limit exceeds any possible distance, so duty lands on target at once.
    localparam logic [12:0] STEP_W = SOFTSTART ? 13'(STEP) : 13'h1FFF;
    localparam logic [11:0] MAX_W  = 12'(DUTY_MAX);
    localparam logic [11:0] MIN_W  = 12'(DUTY_MIN);

    state_t      state_r, state_s;
    logic [11:0] duty_r, duty_s;
    logic [11:0] target_r, target_s;
    logic        en_r, en_s;
    logic        pending_r, pending_s;
    logic        ready_r, ready_s;
    logic        accept_s;
    logic [11:0] clamp_s;
    logic [11:0] diff_s;
    logic [11:0] stepped_s;

    assign accept_s = req_valid && ready_r;

    // Clamp a nonzero request into the legal duty window; zero stays zero.
    always_comb begin
        clamp_s = req_duty;
        if (req_duty == 12'd0) begin
            clamp_s = 12'd0;
        end else if (req_duty < MIN_W) begin
            clamp_s = MIN_W;
        end else if (req_duty > MAX_W) begin
            clamp_s = MAX_W;
        end else begin
            clamp_s = req_duty;
        end
    end

    // Duty value after one period update: move toward target by at most STEP_W, never past it.
    always_comb begin
        diff_s    = (target_r > duty_r) ? (target_r - duty_r) : (duty_r - target_r);
        stepped_s = target_r;
        if ({1'b0, diff_s} > STEP_W) begin
            stepped_s = (target_r > duty_r) ? (duty_r + STEP_W[11:0]) : (duty_r - STEP_W[11:0]);
        end else begin
            stepped_s = target_r;
        end
    end

    // Next-state logic; fault overrides everything, including a same-cycle accept or period_end.
    always_comb begin
        state_s   = state_r;
        duty_s    = duty_r;
        en_s      = en_r;
        target_s  = target_r;
        pending_s = pending_r;
        if (fault) begin
            state_s   = FAULT;
            duty_s    = 12'd0;
            en_s      = 1'b0;
            target_s  = 12'd0;
            pending_s = 1'b0;
        end else begin
            case (state_r)
                FAULT: begin
                    if (fault_clr) begin
                        state_s = IDLE;
                    end else begin
                        state_s = FAULT;
                    end
                end
                IDLE, RAMP, RUN: begin
                    if (period_end) begin
                        duty_s    = stepped_s;
                        pending_s = 1'b0;
                        if (stepped_s != target_r) begin
                            state_s = RAMP;
                            en_s    = 1'b1;
                        end else if (target_r == 12'd0) begin
                            state_s = IDLE;
                            en_s    = 1'b0;
                        end else begin
                            state_s = RUN;
                            en_s    = 1'b1;
                        end
                    end else begin
                        duty_s = duty_r;
                    end
                    // The period update above used the old target; a new one applies from the next period_end.
                    if (accept_s) begin
                        target_s  = clamp_s;
                        pending_s = 1'b1;
                    end else begin
                        target_s = target_r;
                    end
                end
                default: begin
                    state_s   = IDLE;
                    duty_s    = 12'd0;
                    en_s      = 1'b0;
                    target_s  = 12'd0;
                    pending_s = 1'b0;
                end
            endcase
        end
        ready_s = (state_s != FAULT) && !pending_s;
    end

    // State and output registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            duty_r    <= 12'd0;
            en_r      <= 1'b0;
            target_r  <= 12'd0;
            pending_r <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            state_r   <= state_s;
            duty_r    <= duty_s;
            en_r      <= en_s;
            target_r  <= target_s;
            pending_r <= pending_s;
            ready_r   <= ready_s;
        end
    end

    assign req_ready = ready_r;
    assign duty_out  = duty_r;
    assign pwm_en    = en_r;
    assign state_o   = state_r;

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Self-checking bench for pwm_duty_sched: directed scenarios plus random stimulus against a behavioural model.
module tb_pwm_duty_sched;

    localparam int DUTY_MAX = 3500;
    localparam int DUTY_MIN = 150;
    localparam int STEP     = 10;
`ifdef PWM_DUTY_SCHED_SOFTSTART_EN
    localparam bit SS = 1'b1;
`else
    localparam bit SS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [11:0] req_duty = 12'd0;
    logic        period_end = 1'b0;
    logic        fault = 1'b0;
    logic        fault_clr = 1'b0;
    logic        req_ready;
    logic [11:0] duty_out;
    logic        pwm_en;
    logic [1:0]  state_o;
    logic [15:0] dut_vec;

    int checks = 0;
    int failures = 0;

    // Behavioural model: state 0..3, duty and target in clock counts.
    int m_state = 0;
    int m_duty = 0;
    int m_target = 0;
    bit m_en = 1'b0;
    bit m_pending = 1'b0;

    pwm_duty_sched #(.DUTY_MAX(DUTY_MAX), .DUTY_MIN(DUTY_MIN), .STEP(STEP)) dut (
        .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_duty(req_duty),
        .req_ready(req_ready), .period_end(period_end), .fault(fault), .fault_clr(fault_clr),
        .duty_out(duty_out), .pwm_en(pwm_en), .state_o(state_o)
    );

    always #5 clock = ~clock;

    assign dut_vec = {duty_out, pwm_en, state_o, req_ready};

    function automatic int clamp_req(input int r);
        if (r == 0) return 0;
        if (r < DUTY_MIN) return DUTY_MIN;
        if (r > DUTY_MAX) return DUTY_MAX;
        return r;
    endfunction

    function automatic int next_duty(input int d, input int t);
        int lim;
        lim = SS ? STEP : 8192;
        if (t > d) return (t - d > lim) ? d + lim : t;
        return (d - t > lim) ? d - lim : t;
    endfunction

    function automatic logic [15:0] model_vec();
        logic rdy;
        rdy = (m_state != 3) && !m_pending;
        return {12'(m_duty), m_en, 2'(m_state), rdy};
    endfunction

    task automatic model_reset();
        m_state = 0; m_duty = 0; m_target = 0; m_en = 1'b0; m_pending = 1'b0;
    endtask

    task automatic model_edge();
        bit rdy;
        bit acc;
        rdy = (m_state != 3) && !m_pending;
        acc = req_valid && rdy;
        if (fault) begin
            m_state = 3; m_duty = 0; m_en = 1'b0; m_target = 0; m_pending = 1'b0;
        end else if (m_state == 3) begin
            if (fault_clr) m_state = 0;
        end else begin
            if (period_end) begin
                m_pending = 1'b0;
                m_duty = next_duty(m_duty, m_target);
                if (m_duty != m_target) m_state = 1;
                else if (m_target == 0) m_state = 0;
                else m_state = 2;
                m_en = (m_state != 0);
            end
            if (acc) begin
                m_target = clamp_req(int'(req_duty));
                m_pending = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic period();
        repeat (3) tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    task automatic accept(input logic [11:0] d);
        req_valid = 1'b1;
        req_duty = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic settle(input int maxp);
        for (int p = 0; p < maxp && (m_duty != m_target || m_pending); p++) period();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({duty_out, pwm_en, state_o} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs: got duty=%0d en=%0b state=%0d, expected 0/0/0", duty_out, pwm_en, state_o);
        end
        @(negedge clock);
        rst_n = 1'b1;
        tick();
        checks++;
        if (dut_vec !== 16'h0001) begin
            failures++;
            $display("FAIL reset_release: got %h expected 0001", dut_vec);
        end
    endtask

    task automatic test_ramp_up();
        int np;
        np = SS ? 100 : 1;
        accept(12'd1000);
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL ramp_up_pending: req_ready=%0b expected 0", req_ready);
        end
        for (int p = 0; p < np; p++) begin
            period();
            checks++;
            if (duty_out !== 12'(SS ? 10 * (p + 1) : 1000) || dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL ramp_up period %0d: got %h expected %h", p, dut_vec, model_vec());
            end
        end
        checks++;
        if (state_o !== 2'd2 || pwm_en !== 1'b1) begin
            failures++;
            $display("FAIL ramp_up_run: state=%0d en=%0b expected 2/1", state_o, pwm_en);
        end
    endtask

    task automatic test_clamp();
        accept(12'd4000);
        period();
        checks++;
        if (duty_out !== 12'(SS ? 1010 : 3500) || dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL clamp_high_step: got duty=%0d expected %0d", duty_out, SS ? 1010 : 3500);
        end
        settle(400);
        checks++;
        if (duty_out !== 12'd3500 || state_o !== 2'd2) begin
            failures++;
            $display("FAIL clamp_high: got duty=%0d state=%0d expected 3500/2", duty_out, state_o);
        end
        accept(12'd50);
        period();
        checks++;
        if (duty_out !== 12'(SS ? 3490 : 150)) begin
            failures++;
            $display("FAIL clamp_low_step: got duty=%0d expected %0d", duty_out, SS ? 3490 : 150);
        end
        settle(400);
        checks++;
        if (duty_out !== 12'd150 || state_o !== 2'd2) begin
            failures++;
            $display("FAIL clamp_low: got duty=%0d state=%0d expected 150/2", duty_out, state_o);
        end
    endtask

    task automatic test_ramp_down();
        int nd;
        nd = SS ? 50 : 1;
        accept(12'd500);
        settle(100);
        checks++;
        if (duty_out !== 12'd500) begin
            failures++;
            $display("FAIL down_start: got duty=%0d expected 500", duty_out);
        end
        accept(12'd0);
        repeat (nd - 1) period();
        checks++;
        if (duty_out !== 12'(SS ? 10 : 500) || state_o !== 2'(SS ? 1 : 2) || dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL down_last_step: got %h expected %h", dut_vec, model_vec());
        end
        period();
        checks++;
        if ({duty_out, pwm_en, state_o} !== 15'd0) begin
            failures++;
            $display("FAIL down_idle: got duty=%0d en=%0b state=%0d expected 0/0/0", duty_out, pwm_en, state_o);
        end
    endtask

    task automatic test_fault();
        accept(12'd1000);
        repeat (3) period();
        fault = 1'b1;
        req_valid = 1'b1;
        req_duty = 12'd700;
        period_end = 1'b1;
        tick();
        req_valid = 1'b0;
        period_end = 1'b0;
        checks++;
        if (dut_vec !== {12'd0, 1'b0, 2'd3, 1'b0}) begin
            failures++;
            $display("FAIL fault_entry: got %h expected %h", dut_vec, {12'd0, 1'b0, 2'd3, 1'b0});
        end
        fault_clr = 1'b1;
        tick();
        checks++;
        if (state_o !== 2'd3) begin
            failures++;
            $display("FAIL fault_clr_ignored: state=%0d expected 3", state_o);
        end
        fault = 1'b0;
        fault_clr = 1'b0;
        tick();
        checks++;
        if (state_o !== 2'd3 || dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL fault_hold: got %h expected %h", dut_vec, model_vec());
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        checks++;
        if (dut_vec !== 16'h0001) begin
            failures++;
            $display("FAIL fault_exit: got %h expected 0001", dut_vec);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1;
        req_duty = 12'd800;
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        req_duty = 12'd300;
        checks++;
        if (duty_out !== 12'd0 || state_o !== 2'd0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_change: got duty=%0d state=%0d ready=%0b expected 0/0/0", duty_out, state_o, req_ready);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (req_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_ready cycle %0d: got %0b expected 0", i, req_ready);
            end
        end
        req_valid = 1'b0;
        period();
        checks++;
        if (duty_out !== 12'(SS ? 10 : 800) || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_apply: got duty=%0d ready=%0b expected %0d/1", duty_out, req_ready, SS ? 10 : 800);
        end
        settle(100);
        checks++;
        if (duty_out !== 12'd800) begin
            failures++;
            $display("FAIL b2b_final: got duty=%0d expected 800", duty_out);
        end
    endtask

    task automatic test_jump();
        accept(12'd0);
        settle(100);
        checks++;
        if (state_o !== 2'd0 || duty_out !== 12'd0) begin
            failures++;
            $display("FAIL jump_idle: got state=%0d duty=%0d expected 0/0", state_o, duty_out);
        end
        accept(12'd2000);
        period();
        checks++;
        if (duty_out !== 12'(SS ? 10 : 2000) || pwm_en !== 1'b1 || state_o !== 2'(SS ? 1 : 2)) begin
            failures++;
            $display("FAIL jump_apply: got duty=%0d en=%0b state=%0d", duty_out, pwm_en, state_o);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({duty_out, pwm_en, state_o} !== 15'd0) begin
            failures++;
            $display("FAIL reset_async: got duty=%0d en=%0b state=%0d expected 0/0/0", duty_out, pwm_en, state_o);
        end
        model_reset();
        @(negedge clock);
        rst_n = 1'b1;
        tick();
        checks++;
        if (dut_vec !== model_vec() || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_release: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 4000; c++) begin
            req_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: req_duty = 12'd0;
                1: req_duty = 12'd149;
                2: req_duty = 12'd150;
                3: req_duty = 12'd3500;
                4: req_duty = 12'd3501;
                5: req_duty = 12'hFFF;
                default: req_duty = 12'($urandom_range(0, 4095));
            endcase
            period_end = ($urandom_range(0, 2) == 0);
            fault = ($urandom_range(0, 299) == 0);
            fault_clr = ($urandom_range(0, 7) == 0);
            tick();
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                errs++;
                if (errs <= 10) $display("FAIL random cycle %0d: got %h expected %h", c, dut_vec, model_vec());
            end
        end
        req_valid = 1'b0;
        period_end = 1'b0;
        fault = 1'b0;
        fault_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_clamp();
        test_ramp_down();
        test_fault();
        test_back_to_back();
        test_jump();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
